bytecode_fetch_ctrl: RTL and testbench

BYTECODE_FETCH_CTRL -- requirements
Module: bytecode_fetch_ctrl

---
 rtl/bytecode_fetch_ctrl.sv | 118 +++++++++++
 tb/tb_bytecode_fetch_ctrl.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/bytecode_fetch_ctrl.sv
// Bytecode fetch controller: issues sequential byte reads to an instruction RAM
// with a fixed one-cycle read latency, buffers the returned bytes (with the address
// each was fetched from) in a small prefetch FIFO, and presents the FIFO head to the
// instruction decoder through a valid/ready handshake.
//
// Ports
//   clk          : single clock, all state updates on the rising edge
//   reset        : synchronous, active-low reset
//   iram_rd      : read strobe to the instruction RAM
//   iram_adr     : read address (meaningful while iram_rd=1)
//   iram_data    : read data, valid the cycle after iram_rd
//   byte_out     : FIFO head byte
//   byte_valid   : FIFO head is valid
//   byte_ready   : decoder accepts the head when byte_valid=1
//   byte_pc      : address byte_out was fetched from
//   redirect     : restart fetch at redirect_adr (branch/invoke)
//   redirect_adr : new fetch address
//   hold         : pause issuing new reads; in-flight reads still land
//   fifo_count   : number of valid FIFO entries
module bytecode_fetch_ctrl #(
  parameter int unsigned ADR_W = 16,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  output logic                     iram_rd,
  output logic [ADR_W-1:0]         iram_adr,
  input  logic [7:0]               iram_data,
  output logic [7:0]               byte_out,
  output logic                     byte_valid,
  input  logic                     byte_ready,
  output logic [ADR_W-1:0]         byte_pc,
  input  logic                     redirect,
  input  logic [ADR_W-1:0]         redirect_adr,
  input  logic                     hold,
  output logic [$clog2(DEPTH):0]   fifo_count
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  typedef enum logic [1:0] {StRun, StHold, StFlush} state_e;

  state_e                        state_q, state_d;
  logic [ADR_W-1:0]              fetch_ptr_q;
  logic                          inflight_q;
  logic [ADR_W-1:0]              inflight_adr_q;
  logic [PW-1:0]                 wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]                 count_q;
  logic [DEPTH-1:0][7:0]         mem_data_q;
  logic [DEPTH-1:0][ADR_W-1:0]   mem_pc_q;

  logic rd_en, push, pop;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StRun:   if (redirect) state_d = StFlush; else if (hold)  state_d = StHold;
      StHold:  if (redirect) state_d = StFlush; else if (!hold) state_d = StRun;
      StFlush: state_d = StRun;
      default: state_d = StRun;
    endcase
  end

  always_comb begin
    // Count the in-flight read as occupied so a push can never hit a full FIFO.
    rd_en = reset && (state_q == StRun) && !hold && !redirect &&
            ((count_q + {{(CW-1){1'b0}}, inflight_q}) < CW'(DEPTH));
    // A response is dropped if a redirect lands in its arrival cycle; the issue
    // cycle itself can never carry a redirect because rd_en excludes it.
    push       = inflight_q && !redirect && (state_q != StFlush);
    byte_valid = (count_q != '0) && (state_q != StFlush);
    pop        = byte_valid && byte_ready;
  end

  assign iram_rd    = rd_en;
  assign iram_adr   = fetch_ptr_q;
  assign byte_out   = mem_data_q[rd_ptr_q];
  assign byte_pc    = mem_pc_q[rd_ptr_q];
  assign fifo_count = count_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q        <= StRun;
      fetch_ptr_q    <= '0;
      inflight_q     <= 1'b0;
      inflight_adr_q <= '0;
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      count_q        <= '0;
      mem_data_q     <= '0;
      mem_pc_q       <= '0;
    end else begin
      state_q    <= state_d;
      inflight_q <= rd_en;
      if (rd_en) inflight_adr_q <= fetch_ptr_q;

      if (redirect) begin
        // Redirect wins over any push/pop this cycle; the FIFO is emptied anyway.
        fetch_ptr_q <= redirect_adr;
        wr_ptr_q    <= '0;
        rd_ptr_q    <= '0;
        count_q     <= '0;
      end else begin
        if (rd_en) fetch_ptr_q <= fetch_ptr_q + ADR_W'(1);
        if (push) begin
          mem_data_q[wr_ptr_q] <= iram_data;
          mem_pc_q[wr_ptr_q]   <= inflight_adr_q;
          wr_ptr_q             <= wr_ptr_q + PW'(1);
        end
        if (pop) rd_ptr_q <= rd_ptr_q + PW'(1);
        if (push && !pop)      count_q <= count_q + CW'(1);
        else if (pop && !push) count_q <= count_q - CW'(1);
      end
    end
  end

endmodule

// File: tb/tb_bytecode_fetch_ctrl.sv
module tb_bytecode_fetch_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        iram_rd;
  logic [15:0] iram_adr;
  logic [7:0]  iram_data;
  logic [7:0]  byte_out;
  logic        byte_valid;
  logic        byte_ready;
  logic [15:0] byte_pc;
  logic        redirect;
  logic [15:0] redirect_adr;
  logic        hold;
  logic [2:0]  fifo_count;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  bytecode_fetch_ctrl #(.ADR_W(16), .DEPTH(4)) dut (
    .clk          (clk),
    .reset        (reset),
    .iram_rd      (iram_rd),
    .iram_adr     (iram_adr),
    .iram_data    (iram_data),
    .byte_out     (byte_out),
    .byte_valid   (byte_valid),
    .byte_ready   (byte_ready),
    .byte_pc      (byte_pc),
    .redirect     (redirect),
    .redirect_adr (redirect_adr),
    .hold         (hold),
    .fifo_count   (fifo_count)
  );

  // Instruction RAM: returns the low address byte one cycle after a read, junk otherwise.
  always @(posedge clk) begin
    if (iram_rd) iram_data <= iram_adr[7:0];
    else         iram_data <= 8'hEE;
  end

  typedef struct {
    logic        rst;
    logic        hld;
    logic        rdr;
    logic [15:0] radr;
    logic        rdy;
    logic        e_rd;
    logic [15:0] e_adr;
    logic        e_vld;
    logic        chk;
    logic [7:0]  e_out;
    logic [15:0] e_pc;
    logic [2:0]  e_cnt;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic rst, input logic hld, input logic rdr, input logic [15:0] radr,
                     input logic rdy, input logic e_rd, input logic [15:0] e_adr,
                     input logic e_vld, input logic chk, input logic [7:0] e_out,
                     input logic [15:0] e_pc, input logic [2:0] e_cnt);
    vec_t v;
    v = '{rst, hld, rdr, radr, rdy, e_rd, e_adr, e_vld, chk, e_out, e_pc, e_cnt};
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  int n_rd;
  int waited;

  initial begin
    reset = 1'b0; hold = 1'b0; redirect = 1'b0; redirect_adr = '0; byte_ready = 1'b1;
    iram_data = 8'h00;

    //  rst hld rdr radr     rdy  rd  adr      vld chk out    pc       cnt
    add(0, 0, 0, 16'h0000, 1,   0, 16'h0000, 0, 1, 8'h00, 16'h0000, 0); // reset state
    add(1, 0, 0, 16'h0000, 1,   1, 16'h0000, 0, 0, 8'h00, 16'h0000, 0); // first read at 0
    add(1, 0, 0, 16'h0000, 1,   1, 16'h0001, 0, 0, 8'h00, 16'h0000, 0);
    add(1, 0, 0, 16'h0000, 1,   1, 16'h0002, 1, 1, 8'h00, 16'h0000, 1); // valid 2 cycles later
    add(1, 0, 0, 16'h0000, 1,   1, 16'h0003, 1, 1, 8'h01, 16'h0001, 1);
    add(1, 0, 0, 16'h0000, 0,   1, 16'h0004, 1, 1, 8'h02, 16'h0002, 1); // decoder stalls
    add(1, 0, 0, 16'h0000, 0,   1, 16'h0005, 1, 1, 8'h02, 16'h0002, 2);
    add(1, 0, 0, 16'h0000, 0,   0, 16'h0006, 1, 1, 8'h02, 16'h0002, 3); // count+inflight full
    add(1, 0, 0, 16'h0000, 0,   0, 16'h0006, 1, 1, 8'h02, 16'h0002, 4);
    add(1, 0, 0, 16'h0000, 1,   0, 16'h0006, 1, 1, 8'h02, 16'h0002, 4);
    add(1, 0, 0, 16'h0000, 1,   1, 16'h0006, 1, 1, 8'h03, 16'h0003, 3);
    add(1, 0, 0, 16'h0000, 1,   1, 16'h0007, 1, 1, 8'h04, 16'h0004, 2);
    add(1, 0, 0, 16'h0000, 1,   1, 16'h0008, 1, 1, 8'h05, 16'h0005, 2);
    add(1, 0, 1, 16'h1234, 1,   0, 16'h0009, 1, 1, 8'h06, 16'h0006, 2); // redirect, 8 in flight
    add(1, 0, 0, 16'h0000, 1,   0, 16'h1234, 0, 0, 8'h00, 16'h0000, 0); // flush
    add(1, 0, 0, 16'h0000, 1,   1, 16'h1234, 0, 0, 8'h00, 16'h0000, 0);
    add(1, 0, 0, 16'h0000, 1,   1, 16'h1235, 0, 0, 8'h00, 16'h0000, 0);
    add(1, 0, 0, 16'h0000, 1,   1, 16'h1236, 1, 1, 8'h34, 16'h1234, 1);
    add(1, 0, 1, 16'hFFFE, 1,   0, 16'h1237, 1, 1, 8'h35, 16'h1235, 1); // redirect near top
    add(1, 0, 0, 16'h0000, 1,   0, 16'hFFFE, 0, 0, 8'h00, 16'h0000, 0);
    add(1, 0, 0, 16'h0000, 1,   1, 16'hFFFE, 0, 0, 8'h00, 16'h0000, 0);
    add(1, 0, 0, 16'h0000, 1,   1, 16'hFFFF, 0, 0, 8'h00, 16'h0000, 0);
    add(1, 0, 0, 16'h0000, 1,   1, 16'h0000, 1, 1, 8'hFE, 16'hFFFE, 1); // address wrap
    add(1, 0, 0, 16'h0000, 1,   1, 16'h0001, 1, 1, 8'hFF, 16'hFFFF, 1);
    add(1, 0, 0, 16'h0000, 1,   1, 16'h0002, 1, 1, 8'h00, 16'h0000, 1);
    add(1, 0, 0, 16'h0000, 1,   1, 16'h0003, 1, 1, 8'h01, 16'h0001, 1);
    add(1, 1, 0, 16'h0000, 1,   0, 16'h0004, 1, 1, 8'h02, 16'h0002, 1); // hold x3
    add(1, 1, 0, 16'h0000, 1,   0, 16'h0004, 1, 1, 8'h03, 16'h0003, 1); // in-flight 3 landed
    add(1, 1, 0, 16'h0000, 1,   0, 16'h0004, 0, 0, 8'h00, 16'h0000, 0);
    add(1, 0, 0, 16'h0000, 1,   0, 16'h0004, 0, 0, 8'h00, 16'h0000, 0); // leaving HOLD
    add(1, 0, 0, 16'h0000, 1,   1, 16'h0004, 0, 0, 8'h00, 16'h0000, 0);
    add(1, 0, 0, 16'h0000, 1,   1, 16'h0005, 0, 0, 8'h00, 16'h0000, 0);
    add(1, 0, 0, 16'h0000, 1,   1, 16'h0006, 1, 1, 8'h04, 16'h0004, 1);

    step(); // one reset edge before the table starts
    for (int i = 0; i < vecs.size(); i++) begin
      reset = vecs[i].rst; hold = vecs[i].hld; redirect = vecs[i].rdr;
      redirect_adr = vecs[i].radr; byte_ready = vecs[i].rdy;
      #1;
      check($sformatf("v%0d iram_rd", i), 32'(iram_rd), 32'(vecs[i].e_rd));
      check($sformatf("v%0d iram_adr", i), 32'(iram_adr), 32'(vecs[i].e_adr));
      check($sformatf("v%0d byte_valid", i), 32'(byte_valid), 32'(vecs[i].e_vld));
      check($sformatf("v%0d fifo_count", i), 32'(fifo_count), 32'(vecs[i].e_cnt));
      if (vecs[i].chk) begin
        check($sformatf("v%0d byte_out", i), 32'(byte_out), 32'(vecs[i].e_out));
        check($sformatf("v%0d byte_pc", i), 32'(byte_pc), 32'(vecs[i].e_pc));
      end
      step();
    end

    // Stalled decoder from empty: exactly DEPTH reads, then one pop buys one read.
    reset = 1'b0; hold = 1'b0; redirect = 1'b0; byte_ready = 1'b0;
    step();
    reset = 1'b1;
    #1;
    n_rd = 0;
    for (int c = 0; c < 10; c++) begin
      if (iram_rd) n_rd++;
      step();
    end
    check("stall reads", 32'(n_rd), 32'd4);
    check("stall count", 32'(fifo_count), 32'd4);
    check("stall iram_rd", 32'(iram_rd), 32'd0);
    check("stall head", 32'(byte_out), 32'h00);
    byte_ready = 1'b1;
    #1;
    check("pop cycle iram_rd", 32'(iram_rd), 32'd0);
    step();
    byte_ready = 1'b0;
    #1;
    check("after pop head", 32'(byte_out), 32'h01);
    check("after pop pc", 32'(byte_pc), 32'h0001);
    n_rd = 0;
    for (int c = 0; c < 6; c++) begin
      if (iram_rd) begin
        n_rd++;
        check("refill adr", 32'(iram_adr), 32'h0004);
      end
      step();
    end
    check("refill reads", 32'(n_rd), 32'd1);

    // Mid-operation reset with three buffered bytes and one read in flight.
    reset = 1'b0;
    step();
    reset = 1'b1;
    #1;
    waited = 0;
    while (fifo_count != 3'd3 && waited < 20) begin
      step();
      waited++;
    end
    check("reach count 3", 32'(fifo_count), 32'd3);
    reset = 1'b0;
    step();
    #1;
    check("in reset iram_rd", 32'(iram_rd), 32'd0);
    check("in reset count", 32'(fifo_count), 32'd0);
    check("in reset valid", 32'(byte_valid), 32'd0);
    check("in reset byte_out", 32'(byte_out), 32'd0);
    check("in reset byte_pc", 32'(byte_pc), 32'd0);
    reset = 1'b1; byte_ready = 1'b1;
    #1;
    check("restart rd", 32'(iram_rd), 32'd1);
    check("restart adr", 32'(iram_adr), 32'h0000);
    check("restart count", 32'(fifo_count), 32'd0);
    step();
    check("restart adr+1", 32'(iram_adr), 32'h0001);
    check("restart valid early", 32'(byte_valid), 32'd0);
    step();
    check("restart valid", 32'(byte_valid), 32'd1);
    check("restart byte", 32'(byte_out), 32'h00);
    check("restart pc", 32'(byte_pc), 32'h0000);
    check("restart count 1", 32'(fifo_count), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
